// File: rtl/icebus_frame_receiver.sv
// icebus frame receiver: hunts for one of several 32-bit headers, buffers the frame body,
// checks a CRC-16 (poly 0x8005, init 0xFFFF) and presents the payload over valid/ready.
module icebus_frame_receiver #(
    parameter int NUM_FRAME_TYPES  = 4,
    parameter int MAX_FRAME_LENGTH = 32,
    parameter int STAT_WIDTH       = 16,
    localparam int TYPE_W          = (NUM_FRAME_TYPES > 1) ? $clog2(NUM_FRAME_TYPES) : 1,
    localparam int PAYLOAD_BYTES   = MAX_FRAME_LENGTH - 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    input  logic [NUM_FRAME_TYPES*32-1:0] header_i,
    input  logic [NUM_FRAME_TYPES*8-1:0]  frame_len_i,
    input  logic [31:0]                   timeout_cycles_i,
    input  logic                          abort_i,
    output logic                          frame_valid,
    input  logic                          frame_ready,
    output logic [TYPE_W-1:0]             frame_type,
    output logic [7:0]                    frame_payload_len,
    output logic [PAYLOAD_BYTES*8-1:0]    frame_data,
    output logic [STAT_WIDTH-1:0]         frame_count,
    output logic [STAT_WIDTH-1:0]         crc_error_count,
    output logic [STAT_WIDTH-1:0]         timeout_count,
    output logic [STAT_WIDTH-1:0]         overrun_count
);

    localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [7:0] MIN_LEN = 8'd7;
    localparam logic [7:0] MAX_LEN = 8'(MAX_FRAME_LENGTH);

    typedef enum logic [1:0] {HUNT, RECEIVE, CHECK, HOLD} state_t;

    state_t            state, state_next;
    logic [31:0]       hdr_q, hdr_shift;
    logic [TYPE_W-1:0] type_q, match_idx;
    logic [7:0]        pl_q, count_q, match_len, crc_hi_idx, crc_lo_idx;
    logic [15:0]       crc_q;
    logic [31:0]       idle_q, timeout_q;
    logic [7:0]        rx_buf [PAYLOAD_BYTES];
    logic              match_hit, last_byte, timeout_hit, crc_ok, handshake;

    function automatic logic [15:0] crc16_d8(input logic [7:0] d, input logic [15:0] c);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Descending scan so the lowest-index enabled slot wins on duplicate headers.
    always_comb begin
        hdr_shift = {hdr_q[23:0], rx_data};
        match_hit = 1'b0;
        match_idx = '0;
        match_len = '0;
        for (int t = NUM_FRAME_TYPES - 1; t >= 0; t--) begin
            if (frame_len_i[8*t +: 8] >= MIN_LEN && frame_len_i[8*t +: 8] <= MAX_LEN &&
                hdr_shift == header_i[32*t +: 32]) begin
                match_hit = 1'b1;
                match_idx = TYPE_W'(t);
                match_len = frame_len_i[8*t +: 8];
            end
        end
    end

    always_comb begin
        crc_hi_idx  = pl_q - 8'd2;
        crc_lo_idx  = pl_q - 8'd1;
        last_byte   = (count_q == pl_q - 8'd1);
        timeout_hit = (timeout_q != 32'd0) && !rx_valid && (idle_q + 32'd1 == timeout_q);
        crc_ok      = ({rx_buf[crc_hi_idx[IDX_W-1:0]], rx_buf[crc_lo_idx[IDX_W-1:0]]} == crc_q);
        handshake   = frame_valid && frame_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= HUNT;
        else       state <= state_next;
    end

    // abort_i is checked first so it overrides a same-cycle byte or timeout.
    always_comb begin
        state_next = state;
        case (state)
            HUNT:    if (rx_valid && match_hit) state_next = RECEIVE;
            RECEIVE: begin
                if (abort_i)                    state_next = HUNT;
                else if (rx_valid && last_byte) state_next = CHECK;
                else if (timeout_hit)           state_next = HUNT;
            end
            CHECK:   begin
                if (abort_i)     state_next = HUNT;
                else if (crc_ok) state_next = HOLD;
                else             state_next = HUNT;
            end
            HOLD:    if (handshake) state_next = HUNT;
            default: state_next = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == RECEIVE && rx_valid && !abort_i) rx_buf[count_q[IDX_W-1:0]] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_q             <= '0;
            type_q            <= '0;
            pl_q              <= '0;
            count_q           <= '0;
            crc_q             <= '0;
            idle_q            <= '0;
            timeout_q         <= '0;
            frame_valid       <= 1'b0;
            frame_type        <= '0;
            frame_payload_len <= '0;
            frame_data        <= '0;
            frame_count       <= '0;
            crc_error_count   <= '0;
            timeout_count     <= '0;
            overrun_count     <= '0;
        end else begin
            case (state)
                HUNT: begin
                    if (rx_valid) begin
                        hdr_q <= hdr_shift;
                        if (match_hit) begin
                            type_q    <= match_idx;
                            pl_q      <= match_len - 8'd4;
                            count_q   <= '0;
                            crc_q     <= 16'hFFFF;
                            idle_q    <= '0;
                            timeout_q <= timeout_cycles_i;
                        end
                    end
                end
                RECEIVE: begin
                    if (!abort_i) begin
                        if (rx_valid) begin
                            count_q <= count_q + 8'd1;
                            idle_q  <= '0;
                            if (count_q < pl_q - 8'd2) crc_q <= crc16_d8(rx_data, crc_q);
                        end else begin
                            idle_q <= idle_q + 32'd1;
                            if (timeout_hit) timeout_count <= sat_inc(timeout_count);
                        end
                    end
                end
                CHECK: begin
                    if (!abort_i) begin
                        if (crc_ok) begin
                            frame_valid       <= 1'b1;
                            frame_type        <= type_q;
                            frame_payload_len <= pl_q;
                            frame_count       <= sat_inc(frame_count);
                            for (int k = 0; k < PAYLOAD_BYTES; k++) frame_data[8*k +: 8] <= rx_buf[k];
                        end else begin
                            crc_error_count <= sat_inc(crc_error_count);
                        end
                    end
                end
                HOLD: begin
                    if (rx_valid)  overrun_count <= sat_inc(overrun_count);
                    if (handshake) frame_valid   <= 1'b0;
                end
                default: ;
            endcase
            // A stale partial header from the previous frame body must never match.
            if (state != HUNT && state_next == HUNT) hdr_q <= '0;
        end
    end

endmodule

// File: tb/tb_icebus_frame_receiver.sv
// Directed bench for icebus_frame_receiver with a scoreboard of expected frames.
module tb_icebus_frame_receiver;

    typedef struct packed {
        logic [1:0]   ftype;
        logic [7:0]   pl;
        logic [223:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, rx_valid, abort_i, frame_ready, frame_valid;
    logic [7:0]   rx_data, frame_payload_len;
    logic [127:0] header_i;
    logic [31:0]  frame_len_i, timeout_cycles_i;
    logic [1:0]   frame_type;
    logic [223:0] frame_data;
    logic [15:0]  frame_count, crc_error_count, timeout_count, overrun_count;

    exp_t       sb[$];
    logic [7:0] body[$];
    int         pass_count = 0;
    int         check_count = 0;

    icebus_frame_receiver dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .header_i(header_i), .frame_len_i(frame_len_i), .timeout_cycles_i(timeout_cycles_i),
        .abort_i(abort_i), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_type(frame_type), .frame_payload_len(frame_payload_len), .frame_data(frame_data),
        .frame_count(frame_count), .crc_error_count(crc_error_count),
        .timeout_count(timeout_count), .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    function automatic logic [15:0] crcModel();
        logic [15:0] r = 16'hFFFF;
        foreach (body[j]) begin
            for (int i = 7; i >= 0; i--) begin
                if (r[15] ^ body[j][i]) r = {r[14:0], 1'b0} ^ 16'h8005;
                else                    r = {r[14:0], 1'b0};
            end
        end
        return r;
    endfunction

    task automatic sendByte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic fillBody(input int n, input logic [7:0] seed);
        body.delete();
        for (int i = 0; i < n; i++) body.push_back(seed + 8'(i * 7));
    endtask

    // Sends header, body and CRC back to back; the expected frame is queued when it should arrive.
    task automatic applyStimulus(input logic [31:0] hdr, input int slot, input bit corrupt, input bit expect_frame);
        logic [15:0] crc;
        exp_t        e;
        crc = crcModel();
        e   = '0;
        e.ftype = 2'(slot);
        e.pl    = 8'(body.size() + 2);
        foreach (body[k]) e.data[8*k +: 8] = body[k];
        e.data[8*body.size() +: 8]       = crc[15:8];
        e.data[8*(body.size() + 1) +: 8] = crc[7:0];
        if (expect_frame) sb.push_back(e);
        for (int i = 3; i >= 0; i--) sendByte(hdr[8*i +: 8]);
        foreach (body[k]) sendByte(body[k]);
        sendByte(crc[15:8]);
        sendByte(crc[7:0] ^ {7'd0, corrupt});
    endtask

    task automatic waitValid(input string tag);
        int waited = 0;
        while (!frame_valid && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput(tag, 256'(frame_valid), 256'(1));
    endtask

    task automatic receiveFrame(input string tag);
        exp_t         e;
        logic [223:0] mask;
        waitValid({tag, "_valid"});
        if (sb.size() != 0) begin
            e    = sb.pop_front();
            mask = '0;
            for (int k = 0; k < int'(e.pl); k++) mask[8*k +: 8] = 8'hFF;
            checkOutput({tag, "_type"}, 256'(frame_type), 256'(e.ftype));
            checkOutput({tag, "_len"}, 256'(frame_payload_len), 256'(e.pl));
            checkOutput({tag, "_data"}, 256'(frame_data & mask), 256'(e.data));
        end else begin
            check_count++;
            $error("[TB] FAIL %s_scoreboard: observed empty expected entry", tag);
        end
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
        checkOutput({tag, "_drop"}, 256'(frame_valid), 256'(0));
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; abort_i = 1'b0; frame_ready = 1'b0;
        header_i    = {32'hCAFE_0003, 32'h1EAF_0001, 32'h1EAF_0002, 32'h1EAF_0001};
        frame_len_i = {8'd10, 8'd20, 8'd5, 8'd15};
        timeout_cycles_i = 32'd100;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        $display("[TB] reset state");
        checkOutput("rst_valid", 256'(frame_valid), 256'(0));
        checkOutput("rst_type", 256'(frame_type), 256'(0));
        checkOutput("rst_len", 256'(frame_payload_len), 256'(0));
        checkOutput("rst_data", 256'(frame_data), 256'(0));
        checkOutput("rst_counters", 256'({frame_count, crc_error_count, timeout_count, overrun_count}), 256'(0));

        $display("[TB] good frame 123456789");
        body = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        applyStimulus(32'h1EAF_0001, 0, 1'b0, 1'b1);
        checkOutput("latency_check_cycle", 256'(frame_valid), 256'(0));
        @(posedge clk); #1;
        checkOutput("latency_t2", 256'(frame_valid), 256'(1));
        checkOutput("byte0", 256'(frame_data[7:0]), 256'(8'h31));
        checkOutput("crc_bytes", 256'({frame_data[79:72], frame_data[87:80]}), 256'(16'hAEE7));
        receiveFrame("good1");
        checkOutput("frame_count1", 256'(frame_count), 256'(1));

        $display("[TB] bad crc then good frame");
        applyStimulus(32'h1EAF_0001, 0, 1'b1, 1'b0);
        repeat (5) @(posedge clk); #1;
        checkOutput("bad_no_valid", 256'(frame_valid), 256'(0));
        checkOutput("crc_err1", 256'(crc_error_count), 256'(1));
        fillBody(9, 8'h40);
        applyStimulus(32'h1EAF_0001, 0, 1'b0, 1'b1);
        receiveFrame("after_bad");
        checkOutput("frame_count2", 256'(frame_count), 256'(2));

        $display("[TB] inter-byte timeout");
        for (int i = 3; i >= 0; i--) sendByte(8'(32'h1EAF_0001 >> (8 * i)));
        sendByte(8'hA1); sendByte(8'hA2); sendByte(8'hA3);
        repeat (105) @(posedge clk); #1;
        checkOutput("timeout1", 256'(timeout_count), 256'(1));
        checkOutput("timeout_no_valid", 256'(frame_valid), 256'(0));
        fillBody(9, 8'h10);
        applyStimulus(32'h1EAF_0001, 0, 1'b0, 1'b1);
        receiveFrame("after_timeout");
        checkOutput("frame_count3", 256'(frame_count), 256'(3));

        $display("[TB] disabled slot and slot 3 lengths");
        for (int i = 3; i >= 0; i--) sendByte(8'(32'h1EAF_0002 >> (8 * i)));
        for (int i = 0; i < 12; i++) sendByte(8'h55);
        repeat (5) @(posedge clk); #1;
        checkOutput("disabled_no_valid", 256'(frame_valid), 256'(0));
        checkOutput("disabled_counters", 256'({frame_count, crc_error_count}), 256'({16'd3, 16'd1}));
        fillBody(4, 8'h21);
        applyStimulus(32'hCAFE_0003, 3, 1'b0, 1'b1);
        receiveFrame("slot3_len10");
        frame_len_i[31:24] = 8'd7;
        fillBody(1, 8'h77);
        applyStimulus(32'hCAFE_0003, 3, 1'b0, 1'b1);
        receiveFrame("slot3_len7");
        frame_len_i[31:24] = 8'd32;
        fillBody(26, 8'h03);
        applyStimulus(32'hCAFE_0003, 3, 1'b0, 1'b1);
        receiveFrame("slot3_len32");
        checkOutput("frame_count6", 256'(frame_count), 256'(6));

        $display("[TB] backpressure");
        fillBody(9, 8'h61);
        applyStimulus(32'h1EAF_0001, 0, 1'b0, 1'b1);
        waitValid("bp_valid");
        for (int i = 0; i < 50; i++) begin
            if (i == 10 || i == 20 || i == 30) sendByte(8'hEE);
            else begin @(posedge clk); #1; end
        end
        checkOutput("bp_held", 256'(frame_valid), 256'(1));
        checkOutput("overrun3", 256'(overrun_count), 256'(3));
        receiveFrame("bp");

        $display("[TB] abort mid-payload");
        for (int i = 3; i >= 0; i--) sendByte(8'(32'h1EAF_0001 >> (8 * i)));
        sendByte(8'h01); sendByte(8'h02); sendByte(8'h03);
        rx_valid = 1'b1; rx_data = 8'h99; abort_i = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; abort_i = 1'b0;
        checkOutput("abort_counters", 256'({frame_count, crc_error_count, timeout_count, overrun_count}),
                    256'({16'd7, 16'd1, 16'd1, 16'd3}));
        fillBody(9, 8'hB0);
        applyStimulus(32'h1EAF_0001, 0, 1'b0, 1'b1);
        receiveFrame("after_abort");

        $display("[TB] reset during HOLD");
        fillBody(9, 8'hC0);
        applyStimulus(32'h1EAF_0001, 0, 1'b0, 1'b0);
        waitValid("hold_valid");
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("hold_rst_valid", 256'(frame_valid), 256'(0));
        checkOutput("hold_rst_data", 256'(frame_data), 256'(0));
        checkOutput("hold_rst_misc", 256'({frame_type, frame_payload_len}), 256'(0));
        checkOutput("hold_rst_counters", 256'({frame_count, crc_error_count, timeout_count, overrun_count}), 256'(0));
        checkOutput("sb_drained", 256'(sb.size()), 256'(0));

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/icebus_frame_receiver.md
Name: icebus_frame_receiver

Overview:
- Parametrised byte-stream frame receiver for the icebus motor bus. It sits between uart_rx and the bus-master state machines.
- Hunts for any of NUM_FRAME_TYPES 32-bit headers, then buffers the rest of the frame using a per-type runtime-configurable length.
- Checks a streaming CRC-16 (x^16+x^15+x^2+1) and hands the frame to the consumer over a valid/ready handshake.
- Adds what the single-type matcher lacked: multiple frame types, inter-byte timeout, backpressure and saturating error statistics.

Parameters:
- NUM_FRAME_TYPES, 4, number of header/length slots; header slot 0 has the highest match priority.
- MAX_FRAME_LENGTH, 32, maximum frame length in bytes, including the 4-byte header and 2 CRC bytes.
- STAT_WIDTH, 16, width of each saturating statistics counter.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte.
- rx_data  in  8  received byte.
- header_i  in  NUM_FRAME_TYPES*32  header per slot; slot t = bits [32t+31:32t]; first byte on the wire = MSB.
- frame_len_i  in  NUM_FRAME_TYPES*8  total frame length per slot.
- timeout_cycles_i  in  32  inter-byte timeout in clk cycles; 0 disables the timeout.
- abort_i  in  1  forces a return to HUNT (for example, on a bus-master timeout).
- frame_valid  out  1  a CRC-checked frame is available.
- frame_ready  in  1  consumer accepts the frame.
- frame_type  out  $clog2(NUM_FRAME_TYPES) (min 1)  index of the matched slot.
- frame_payload_len  out  8  payload bytes, excluding the header and including the CRC bytes.
- frame_data  out  (MAX_FRAME_LENGTH-4)*8  payload; byte k = bits [8k+7:8k]; byte 0 = motor id.
- frame_count, crc_error_count, timeout_count, overrun_count  out  STAT_WIDTH each  saturating statistics.

Behaviour:
- Reset (synchronous): state HUNT, header shift register cleared to 0. frame_valid=0, frame_type=0, frame_payload_len=0, frame_data=0, all counters=0.
- A slot is enabled only if 7 <= frame_len_i[t] <= MAX_FRAME_LENGTH. A disabled slot never matches.
- Derived value: payload length PL = len-4.
- HUNT:
  - On rx_valid, shift rx_data into a 4-byte register.
  - The comparison uses the updated value (the 3 previous bytes plus the new byte).
  - On a match with the lowest-index enabled slot t: latch t and PL, set count=0, crc=16'hFFFF, go to RECEIVE on the next cycle.
  - Headers are matched on the same cycle as the completing byte; no extra byte is consumed.
- RECEIVE, per rx_valid:
  - buf[count] <= rx_data.
  - If count < PL-2, crc <= nextCRC16_D8(rx_data, crc); D[7] is the first serial bit.
  - count++. When the byte just stored is index PL-1, go to CHECK.
- CRC is non-reflected with xorout 0. Received CRC = {buf[PL-2], buf[PL-1]}, high byte first.
- Timeout: an idle counter resets on each rx_valid in RECEIVE. If timeout_cycles_i != 0 and the counter reaches timeout_cycles_i: go to HUNT, timeout_count++.
- CHECK (exactly 1 cycle):
  - On CRC match: copy buf to frame_data, set frame_type and frame_payload_len, frame_valid <= 1, frame_count++, go to HOLD.
  - On mismatch: crc_error_count++, go to HUNT.
- Latency: final byte strobed at cycle T -> CHECK at T+1 -> frame_valid=1 from T+2.
- HOLD:
  - frame_valid stays high and frame_data/type/len stay stable until a cycle with frame_valid && frame_ready.
  - On that handshake: frame_valid <= 0, go to HUNT.
  - Bytes arriving in HOLD are discarded and overrun_count++ for each.
  - Unused buf bytes beyond PL hold stale data; the consumer uses frame_payload_len.
- The header shift register is cleared on every entry to HUNT, so a partial header from the previous frame body cannot match.
- abort_i: from RECEIVE or CHECK, go to HUNT next cycle with no counter change and the frame discarded. It is ignored in HUNT and HOLD.
- abort_i takes precedence over a same-cycle rx_valid or timeout.
- Counters saturate at all-ones, with no wrap.
- Config inputs are sampled only at header match; changes mid-frame do not affect the frame in progress.
- Reset mid-frame or during HOLD: the immediate return to the reset values applies.

Test Plan:
- Good frame: header 0x1EAF_0001 in slot 0, len 15, payload "123456789" + CRC 0xAE 0xE7 -> frame_valid at T+2. Checks: frame_type=0, frame_payload_len=11, frame_data byte0=0x31, frame_count=1.
- Bad CRC: same frame with last byte 0xE6 -> no frame_valid, crc_error_count=1. A following good frame is accepted.
- Timeout: timeout_cycles_i=100, send the header plus 3 payload bytes, then stall 100 cycles -> timeout_count=1, state HUNT. A full good frame after that is accepted.
- Priority/length: slots 0 and 2 both hold the same header (len 15 vs 20); slot 1 len=5 (disabled) -> frame_type=0. Slot 1's header never matches.
- Backpressure: frame_ready=0 for 50 cycles while 3 further bytes arrive -> frame_valid is held with stable data and overrun_count=3. frame_ready=1 -> frame_valid falls the next cycle.
- Reset/abort: abort_i asserted mid-payload -> no counter change and the next frame is received intact. Reset pulsed in HOLD -> all outputs 0 the next cycle.
